mastermind_game_ctrl: RTL and testbench

MASTERMIND_GAME_CTRL -- requirements
Module: mastermind_game_ctrl

---
 rtl/mastermind_game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mastermind_game_ctrl: debounced push-button game sequencer for a         |
// | Mastermind core. MM_FIXED_CODE_EN selects FIXED_CODE instead of an LFSR. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mastermind_game_ctrl #(
  parameter logic [15:0] DB_CYCLES    = 16'd1000,
  parameter logic [3:0]  MAX_ATTEMPTS = 4'd10,
  parameter logic [15:0] FIXED_CODE   = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pb_i,
  input  logic [15:0] guess_i,
  input  logic [7:0]  positions_matched_i,
  input  logic [7:0]  numbers_matched_i,
  output logic [15:0] code_o,
  output logic [15:0] guess_o,
  output logic [7:0]  result_pos_o,
  output logic [7:0]  result_num_o,
  output logic        result_valid_o,
  output logic [3:0]  attempts_o,
  output logic [2:0]  state_o,
  output logic        lock_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_LOSE = 3'd4;

  logic [1:0]  sync_q, sync_d;
  logic        db_level_q, db_level_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        w_press;
  logic [15:0] w_code_src;

  logic [2:0]  state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [15:0] guess_q, guess_d;
  logic [7:0]  result_pos_q, result_pos_d;
  logic [7:0]  result_num_q, result_num_d;
  logic        result_valid_q, result_valid_d;
  logic [3:0]  attempts_q, attempts_d;
  logic        lock_q, lock_d;
  logic [3:0]  w_attempts_inc;

`ifdef MM_FIXED_CODE_EN
  assign w_code_src = FIXED_CODE;
`else
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 shifting toward the MSB
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // The all-zero fallback is unreachable from a non-zero seed; it only guards against a bad seed edit.
  assign w_code_src = (lfsr_q == 16'h0000) ? FIXED_CODE : lfsr_q;
`endif

  always_comb begin
    sync_d     = {sync_q[0], pb_i};
    db_cnt_d   = 16'd0;
    db_level_d = db_level_q;
    w_press    = 1'b0;
    if (sync_q[1] != db_level_q) begin
      if ((db_cnt_q + 16'd1) >= DB_CYCLES) begin
        db_level_d = sync_q[1];
        w_press    = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  assign w_attempts_inc = (attempts_q < MAX_ATTEMPTS) ? attempts_q + 4'd1 : attempts_q;

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    guess_d        = guess_q;
    result_pos_d   = result_pos_q;
    result_num_d   = result_num_q;
    result_valid_d = 1'b0;
    attempts_d     = attempts_q;
    case (state_q)
      S_IDLE: begin
        if (w_press) begin
          code_d       = w_code_src;
          attempts_d   = 4'd0;
          result_pos_d = 8'd0;
          result_num_d = 8'd0;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_press) begin
          guess_d = guess_i;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // Any press landing here is intentionally dropped
        result_pos_d   = positions_matched_i;
        result_num_d   = numbers_matched_i;
        result_valid_d = 1'b1;
        attempts_d     = w_attempts_inc;
        if (positions_matched_i == 8'd4)        state_d = S_WIN;
        else if (w_attempts_inc == MAX_ATTEMPTS) state_d = S_LOSE;
        else                                     state_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (w_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    lock_d = (state_d != S_WIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= 2'b00;
      db_level_q     <= 1'b0;
      db_cnt_q       <= 16'd0;
      state_q        <= S_IDLE;
      code_q         <= 16'd0;
      guess_q        <= 16'd0;
      result_pos_q   <= 8'd0;
      result_num_q   <= 8'd0;
      result_valid_q <= 1'b0;
      attempts_q     <= 4'd0;
      lock_q         <= 1'b1;
    end else begin
      sync_q         <= sync_d;
      db_level_q     <= db_level_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      code_q         <= code_d;
      guess_q        <= guess_d;
      result_pos_q   <= result_pos_d;
      result_num_q   <= result_num_d;
      result_valid_q <= result_valid_d;
      attempts_q     <= attempts_d;
      lock_q         <= lock_d;
    end
  end

  assign code_o         = code_q;
  assign guess_o        = guess_q;
  assign result_pos_o   = result_pos_q;
  assign result_num_o   = result_num_q;
  assign result_valid_o = result_valid_q;
  assign attempts_o     = attempts_q;
  assign state_o        = state_q;
  assign lock_o         = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mastermind_game_ctrl: scoreboard bench for mastermind_game_ctrl.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mastermind_game_ctrl;

  localparam logic [15:0] DB   = 16'd4;
  localparam logic [3:0]  MAXA = 4'd3;
  localparam logic [15:0] FIX  = 16'h1234;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_LOSE = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pb_i;
  logic [15:0] guess_i;
  logic [7:0]  pos_i, num_i;
  logic [15:0] code_o, guess_o;
  logic [7:0]  result_pos_o, result_num_o;
  logic        result_valid_o, lock_o;
  logic [3:0]  attempts_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  mastermind_game_ctrl #(
    .DB_CYCLES(DB), .MAX_ATTEMPTS(MAXA), .FIXED_CODE(FIX)
  ) dut (
    .clk(clk), .rst(rst), .pb_i(pb_i), .guess_i(guess_i),
    .positions_matched_i(pos_i), .numbers_matched_i(num_i),
    .code_o(code_o), .guess_o(guess_o),
    .result_pos_o(result_pos_o), .result_num_o(result_num_o),
    .result_valid_o(result_valid_o), .attempts_o(attempts_o),
    .state_o(state_o), .lock_o(lock_o)
  );

  typedef struct packed {
    logic [7:0] pos;
    logic [7:0] num;
    logic [3:0] att;
    logic [2:0] st;
    logic       lock;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] mdl_lfsr;
  logic [15:0] press_code;
  logic [15:0] game_code;

  // Golden LFSR: x^16+x^14+x^13+x^11, seed ACE1
  always @(posedge clk) begin
    if (rst) mdl_lfsr <= 16'hACE1;
    else     mdl_lfsr <= {mdl_lfsr[14:0], mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Press lands exactly DB+2 edges after pb_i rises (2 sync flops + DB stable samples)
  task automatic do_press(input string tag, input logic [2:0] before_st, input logic [2:0] after_st);
    pb_i = 1'b1;
    repeat (int'(DB) + 1) @(negedge clk);
    check({tag, "_pre_state"}, {29'd0, state_o}, {29'd0, before_st});
`ifdef MM_FIXED_CODE_EN
    press_code = FIX;
`else
    press_code = mdl_lfsr;
`endif
    @(negedge clk);
    check({tag, "_post_state"}, {29'd0, state_o}, {29'd0, after_st});
  endtask

  task automatic do_release();
    pb_i = 1'b0;
    repeat (int'(DB) + 3) @(negedge clk);
  endtask

  task automatic play_guess(input logic [15:0] g, input logic [7:0] p, input logic [7:0] n,
                            input logic [3:0] att, input logic [2:0] st, input logic lk);
    guess_i = g;
    pos_i   = p;
    num_i   = n;
    sb_q.push_back('{pos: p, num: n, att: att, st: st, lock: lk});
    do_press("guess", S_PLAY, S_EVAL);
    check("guess_reg", guess_o, g);
    @(negedge clk);
    check("eval_exit_state", state_o, st);
    check("eval_exit_lock", lock_o, lk);
    do_release();
  endtask

  // Monitor: every result_valid_o pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (result_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", result_valid_o, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pos",   result_pos_o, mon_e.pos);
        check("sb_num",   result_num_o, mon_e.num);
        check("sb_att",   attempts_o,   mon_e.att);
        check("sb_state", state_o,      mon_e.st);
        check("sb_lock",  lock_o,       mon_e.lock);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; pb_i = 1'b0; guess_i = 16'h0; pos_i = 8'd0; num_i = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_state",  state_o, S_IDLE);
    check("rst_code",   code_o, 16'h0);
    check("rst_guess",  guess_o, 16'h0);
    check("rst_pos",    result_pos_o, 8'd0);
    check("rst_num",    result_num_o, 8'd0);
    check("rst_valid",  result_valid_o, 1'b0);
    check("rst_att",    attempts_o, 4'd0);
    check("rst_lock",   lock_o, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Game 1: code from source, immediate win
    do_press("start1", S_IDLE, S_PLAY);
    check("code_load", code_o, press_code);
    check("code_nonzero", (code_o != 16'h0), 1'b1);
    game_code = press_code;
    do_release();
    play_guess(16'h1234, 8'd4, 8'd0, 4'd1, S_WIN, 1'b0);
    guess_i = 16'hFFFF; pos_i = 8'd0; num_i = 8'd0;
    do_press("win_exit", S_WIN, S_IDLE);
    check("hold_code",  code_o, game_code);
    check("hold_guess", guess_o, 16'h1234);
    check("hold_pos",   result_pos_o, 8'd4);
    check("hold_att",   attempts_o, 4'd1);
    check("idle_lock",  lock_o, 1'b1);
    do_release();

    // Holding the button gives one press only
    do_press("hold", S_IDLE, S_PLAY);
    check("clear_att", attempts_o, 4'd0);
    check("clear_pos", result_pos_o, 8'd0);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (state_o !== S_PLAY) bad++;
    end
    check("hold_single_press", bad, 0);
    do_release();

    // Game 2: run out of attempts
    play_guess(16'h5678, 8'd0, 8'd0, 4'd1, S_PLAY, 1'b1);
    play_guess(16'h5678, 8'd2, 8'd1, 4'd2, S_PLAY, 1'b1);
    play_guess(16'h5678, 8'd3, 8'd1, 4'd3, S_LOSE, 1'b1);
    do_press("lose_exit", S_LOSE, S_IDLE);
    check("lose_hold_att", attempts_o, 4'd3);
    do_release();

    // Game 3: win on final attempt takes priority over lose
    do_press("start3", S_IDLE, S_PLAY);
    do_release();
    play_guess(16'h4321, 8'd1, 8'd3, 4'd1, S_PLAY, 1'b1);
    play_guess(16'h2143, 8'd0, 8'd4, 4'd2, S_PLAY, 1'b1);
    play_guess(16'h1234, 8'd4, 8'd0, 4'd3, S_WIN,  1'b0);
    do_press("win3_exit", S_WIN, S_IDLE);
    do_release();

    // Bouncing button never accepted
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      pb_i = ~pb_i;
      repeat (2) @(negedge clk);
      if (state_o !== S_IDLE) bad++;
    end
    check("bounce_no_press", bad, 0);
    do_release();

    // Reset during EVAL
    do_press("start4", S_IDLE, S_PLAY);
    do_release();
    guess_i = 16'h9abc; pos_i = 8'd1; num_i = 8'd1;
    do_press("eval4", S_PLAY, S_EVAL);
    rst = 1'b1;
    @(negedge clk);
    check("rst_eval_state", state_o, S_IDLE);
    check("rst_eval_att",   attempts_o, 4'd0);
    check("rst_eval_valid", result_valid_o, 1'b0);
    check("rst_eval_lock",  lock_o, 1'b1);
    rst = 1'b0;
    // Button still held: needs a full debounce period after reset
    do_press("post_rst", S_IDLE, S_PLAY);
    check("post_rst_code", code_o, press_code);
    do_release();

    // Press coinciding with reset is ignored
    pb_i = 1'b1;
    repeat (int'(DB) + 1) @(negedge clk);
    check("coinc_pre_state", state_o, S_PLAY);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    pb_i = 1'b0;
    check("coinc_state", state_o, S_IDLE);
    repeat (int'(DB) + 3) @(negedge clk);
    check("coinc_stays_idle", state_o, S_IDLE);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
